trap_controller: RTL and testbench
==================================

# trap_controller

Machine-mode trap sequencer for the RISC-V core, paired with the CSR file: it drives `exception_occurred`, `exception_returned`, `new_mepc`, `new_mcause` and `new_mtval`, and consumes `csr_mstatus`, `csr_mie`, `csr_mip`, `csr_mtvec` and `csr_mepc`.
- Arbitrates interrupts, synchronous exceptions and `mret` at the execute/commit boundary.
- Kills the offending instruction, stalls the pipeline and redirects the PC through a three-state FSM.

## Interface
Parameters:
- `RESET_PC`, 32'h0: redirect target emitted on no path; reserved for boot-vector override, must equal core reset PC.

Ports:
- `clk`  in  1  core clock
- `rst_sync`  in  1  synchronous active-high reset
- `ex_valid`  in  1  instruction in execute is valid
- `ex_pc`  in  32  PC of that instruction
- `ex_inst`  in  32  raw instruction word
- `ex_fetch_misaligned`, `ex_illegal`, `ex_ebreak`, `ex_ecall`, `ex_mret`  in  1 each  decoded trap requests
- `csr_wen`  in  1  CSR write this cycle (from decoder, pre-stall)
- `csr_mstatus`, `csr_mie`, `csr_mip`, `csr_mtvec`, `csr_mepc`  in  32 each  CSR state
- `ex_kill`  out  1  combinational: squash execute instruction (no writeback, no CSR write)
- `stall_n`  out  1  0 while sequencing
- `exception_occurred`, `exception_returned`  out  1  one-cycle pulses to CSR
- `new_mepc`, `new_mcause`, `new_mtval`  out  32
- `pc_redirect`  out  1  load `redirect_pc` into fetch
- `redirect_pc`  out  32

## Operation
- Interrupt pending: `int_req = csr_mstatus[3] & |(csr_mie & csr_mip)`, bits 11/3/7 only. Priority: MEI (cause 11) > MSI (3) > MTI (7). `mcause[31]=1`.
- Synchronous priority: fetch-misaligned (0) > illegal (2) > ebreak (3) > ecall (11). `mcause[31]=0`.
- Interrupt beats a synchronous exception on the same instruction. Any trap beats `ex_mret`.
- Interrupts are ignored in any cycle with `csr_wen=1`. They are taken on the next cycle. This prevents the CSR write-over-trap priority from dropping the `mstatus` update.
- `new_mepc = ex_pc`. `new_mtval = ex_inst` for illegal, `ex_pc` for fetch-misaligned, else 0.
- Trap target is `{csr_mtvec[31:2],2'b00}`. Vectored mode is described under Configuration.
- `mret` target is `csr_mepc`.
- FSM states and transitions:
  - IDLE → TRAP when `ex_valid` and any trap is selected.
  - IDLE → RET when `ex_valid & ex_mret` and no trap is selected.
  - TRAP → REDIRECT and RET → REDIRECT unconditionally.
  - REDIRECT → IDLE.
- `ex_kill` = IDLE and (trap or mret) selected; combinational in the detect cycle N.
- The IDLE→TRAP/RET edge registers cause, mepc, mtval and target.
- Interrupt sampling is suppressed in TRAP, RET and REDIRECT. The `mstatus` update is always visible before the next evaluation.

## Timing
- Cycle N: detection, `ex_kill=1`, `stall_n=1`.
- Cycle N+1 (TRAP/RET): the matching `exception_occurred`/`exception_returned` is 1, `stall_n=0`; the CSR updates on the N+1→N+2 edge.
- Cycle N+2 (REDIRECT): `pc_redirect=1`, `redirect_pc` valid, `stall_n=0`.
- Cycle N+3: IDLE, `stall_n=1`, first target instruction may be fetched.
- Outputs other than `ex_kill` and `stall_n` are registered. `new_*` hold their last value outside the pulse.
- Reset values:
  - state = IDLE
  - `stall_n = 1`
  - `exception_occurred`, `exception_returned`, `pc_redirect` = 0
  - `new_mepc`, `new_mcause`, `new_mtval`, `redirect_pc` = 0
  - `ex_kill = 0`
- `rst_sync` in any state returns to IDLE next cycle. Pending pulses and redirects are dropped.
- `ex_valid=0`: no synchronous trap or mret is taken, and no interrupt is taken (no boundary PC).

## Configuration
- `TRAP_VECTORED_EN` defined:
  - When `csr_mtvec[1:0]==2'b01`, the interrupt target is `{mtvec[31:2],2'b00} + 4*cause[4:0]`.
  - Synchronous exceptions always go to the base.
  - Mode 2'b1x is treated as direct.
- Undefined: direct mode only; `mtvec[1:0]` ignored; the adder is removed.

## Test plan
- ecall, `ex_pc=0x100`, `mtvec=0x200`: expect
  - `ex_kill` at N
  - `exception_occurred` at N+1 with `mcause=0x0000000B`, `mepc=0x100`, `mtval=0`
  - `pc_redirect` at N+2 to `0x200`
- MEI with `mstatus=0x8`, `mie=0x800`, `mip=0x800`, `mtvec=0x201`, VECTORED on: expect `mcause=0x8000000B`, redirect `0x22C`. VECTORED off: redirect `0x200`.
- MTI and MSI pending with ecall in execute: expect `mcause=0x80000003`, `mepc=ex_pc`, ecall squashed.
- `ex_mret`, `csr_mepc=0x104`: expect `exception_returned` at N+1, redirect `0x104` at N+2, `exception_occurred=0`.
- Interrupt pending with `csr_wen=1`: no kill that cycle; trap taken the following cycle.
- `rst_sync` asserted during TRAP: IDLE next cycle, `pc_redirect` never asserted, `stall_n=1`.

Source files
------------

// File: rtl/trap_controller_if.sv
// trap_controller_if: execute-stage, CSR-state and redirect signals exchanged between the
// pipeline/CSR file (master) and the machine-mode trap sequencer (slave).
interface trap_controller_if;
   // Execute-stage instruction and its decoded trap requests
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_inst;
   logic        ex_fetch_misaligned;
   logic        ex_illegal;
   logic        ex_ebreak;
   logic        ex_ecall;
   logic        ex_mret;
   logic        csr_wen;
   // CSR state consumed by the sequencer
   logic [31:0] csr_mstatus;
   logic [31:0] csr_mie;
   logic [31:0] csr_mip;
   logic [31:0] csr_mtvec;
   logic [31:0] csr_mepc;
   // Sequencer outputs
   logic        ex_kill;
   logic        stall_n;
   logic        exception_occurred;
   logic        exception_returned;
   logic [31:0] new_mepc;
   logic [31:0] new_mcause;
   logic [31:0] new_mtval;
   logic        pc_redirect;
   logic [31:0] redirect_pc;

   modport master (
      output ex_valid, ex_pc, ex_inst, ex_fetch_misaligned, ex_illegal, ex_ebreak, ex_ecall,
             ex_mret, csr_wen, csr_mstatus, csr_mie, csr_mip, csr_mtvec, csr_mepc,
      input  ex_kill, stall_n, exception_occurred, exception_returned, new_mepc, new_mcause,
             new_mtval, pc_redirect, redirect_pc
   );

   modport slave (
      input  ex_valid, ex_pc, ex_inst, ex_fetch_misaligned, ex_illegal, ex_ebreak, ex_ecall,
             ex_mret, csr_wen, csr_mstatus, csr_mie, csr_mip, csr_mtvec, csr_mepc,
      output ex_kill, stall_n, exception_occurred, exception_returned, new_mepc, new_mcause,
             new_mtval, pc_redirect, redirect_pc
   );
endinterface

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer. Arbitrates interrupts, synchronous exceptions
// and mret at the execute/commit boundary, kills the instruction, stalls for two cycles
// (TRAP/RET then REDIRECT) and redirects fetch.
// Optional feature: define TRAP_VECTORED_EN for vectored interrupt targets (mtvec mode 2'b01).
module trap_controller #(
   // Boot-vector override hook; only used as the reset value of the redirect target.
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input logic             clk,
   input logic             rst_sync,
   trap_controller_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StTrap, StRet, StRedirect} state_e;

   state_e      state_q, state_d;
   logic        occurred_q, returned_q, redirect_q;
   logic [31:0] mepc_q, mcause_q, mtval_q, target_q;

   logic        irq_mei, irq_msi, irq_mti;
   logic        irq_ok, int_sel, exc_sel, trap_sel, ret_sel, detect;
   logic [31:0] sel_cause, sel_mtval, trap_base, trap_target, next_target;
   logic        unused_bits;

   // Only the three machine-level interrupt lines participate
   assign irq_mei = bus.csr_mie[11] & bus.csr_mip[11];
   assign irq_msi = bus.csr_mie[3] & bus.csr_mip[3];
   assign irq_mti = bus.csr_mie[7] & bus.csr_mip[7];

   // A pending CSR write may be updating mstatus/mie, so interrupts wait one cycle for it
   assign irq_ok   = bus.ex_valid & bus.csr_mstatus[3] & ~bus.csr_wen & (state_q == StIdle);
   assign int_sel  = irq_ok & (irq_mei | irq_msi | irq_mti);
   assign exc_sel  = bus.ex_valid & (bus.ex_fetch_misaligned | bus.ex_illegal |
                                     bus.ex_ebreak | bus.ex_ecall);
   assign trap_sel = int_sel | exc_sel;
   assign ret_sel  = bus.ex_valid & bus.ex_mret & ~trap_sel;
   assign detect   = (state_q == StIdle) & (trap_sel | ret_sel);

   // Cause and trap value of the winning trap source
   always_comb begin
      sel_cause = '0;
      sel_mtval = '0;
      if (int_sel) begin
         sel_cause[31] = 1'b1;
         if (irq_mei)      sel_cause[4:0] = 5'd11;
         else if (irq_msi) sel_cause[4:0] = 5'd3;
         else              sel_cause[4:0] = 5'd7;
      end else if (bus.ex_fetch_misaligned) begin
         sel_cause[4:0] = 5'd0;
         sel_mtval      = bus.ex_pc;
      end else if (bus.ex_illegal) begin
         sel_cause[4:0] = 5'd2;
         sel_mtval      = bus.ex_inst;
      end else if (bus.ex_ebreak) begin
         sel_cause[4:0] = 5'd3;
      end else if (bus.ex_ecall) begin
         sel_cause[4:0] = 5'd11;
      end
   end

   assign trap_base = {bus.csr_mtvec[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   // Only interrupts vector; synchronous exceptions and modes 2'b1x use the base
   assign trap_target = (int_sel && (bus.csr_mtvec[1:0] == 2'b01)) ?
                        trap_base + {25'b0, sel_cause[4:0], 2'b00} : trap_base;
   assign unused_bits = ^{bus.csr_mstatus[31:4], bus.csr_mstatus[2:0],
                          bus.csr_mie[31:12], bus.csr_mie[10:8], bus.csr_mie[6:4],
                          bus.csr_mie[2:0], bus.csr_mip[31:12], bus.csr_mip[10:8],
                          bus.csr_mip[6:4], bus.csr_mip[2:0]};
`else
   assign trap_target = trap_base;
   assign unused_bits = ^{bus.csr_mstatus[31:4], bus.csr_mstatus[2:0],
                          bus.csr_mie[31:12], bus.csr_mie[10:8], bus.csr_mie[6:4],
                          bus.csr_mie[2:0], bus.csr_mip[31:12], bus.csr_mip[10:8],
                          bus.csr_mip[6:4], bus.csr_mip[2:0], bus.csr_mtvec[1:0]};
`endif

   assign next_target = trap_sel ? trap_target : bus.csr_mepc;

   // Next-state logic of the sequencer
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (trap_sel)     state_d = StTrap;
            else if (ret_sel) state_d = StRet;
         end
         StTrap:     state_d = StRedirect;
         StRet:      state_d = StRedirect;
         StRedirect: state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // State register, registered pulses and trap record captured on the detect edge
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state_q    <= StIdle;
         occurred_q <= 1'b0;
         returned_q <= 1'b0;
         redirect_q <= 1'b0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         target_q   <= RESET_PC;
      end else begin
         state_q    <= state_d;
         occurred_q <= (state_d == StTrap);
         returned_q <= (state_d == StRet);
         redirect_q <= (state_d == StRedirect);
         if (detect) begin
            target_q <= next_target;
            if (trap_sel) begin
               mepc_q   <= bus.ex_pc;
               mcause_q <= sel_cause;
               mtval_q  <= sel_mtval;
            end
         end
      end
   end

   assign bus.ex_kill            = detect & ~rst_sync;
   assign bus.stall_n            = (state_q == StIdle);
   assign bus.exception_occurred = occurred_q;
   assign bus.exception_returned = returned_q;
   assign bus.new_mepc           = mepc_q;
   assign bus.new_mcause         = mcause_q;
   assign bus.new_mtval          = mtval_q;
   assign bus.pc_redirect        = redirect_q;
   assign bus.redirect_pc        = target_q;

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed vector table, hand-written multi-cycle sequences and random
// transactions checked against a priority-list reference model.
module tb_trap_controller;

   logic clk = 1'b0;
   logic rst_sync;
   always #5 clk = ~clk;

   trap_controller_if bus_if ();

   trap_controller #(.RESET_PC(32'h0)) dut (
      .clk      (clk),
      .rst_sync (rst_sync),
      .bus      (bus_if)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        valid;
      logic [31:0] pc, inst;
      logic        fm, ill, ebrk, ecall, mret, wen;
      logic [31:0] mstatus, mie, mip, mtvec, mepc;
      logic        e_trap, e_ret;
      logic [31:0] e_cause, e_mtval, e_target;
   } vec_t;

`ifdef TRAP_VECTORED_EN
   localparam logic [31:0] MeiVecTgt = 32'h0000_022C;
   localparam logic [31:0] MsiVecTgt = 32'h0000_010C;
`else
   localparam logic [31:0] MeiVecTgt = 32'h0000_0200;
   localparam logic [31:0] MsiVecTgt = 32'h0000_0100;
`endif

   // req = {fetch_misaligned, illegal, ebreak, ecall, mret, csr_wen}
   function automatic vec_t mk(input logic valid, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [5:0] req, input logic [31:0] mstatus,
                               input logic [31:0] mie, input logic [31:0] mip,
                               input logic [31:0] mtvec, input logic [31:0] mepc,
                               input logic et, input logic er, input logic [31:0] ec,
                               input logic [31:0] em, input logic [31:0] etg);
      vec_t v;
      v.valid = valid; v.pc = pc; v.inst = inst;
      {v.fm, v.ill, v.ebrk, v.ecall, v.mret, v.wen} = req;
      v.mstatus = mstatus; v.mie = mie; v.mip = mip; v.mtvec = mtvec; v.mepc = mepc;
      v.e_trap = et; v.e_ret = er; v.e_cause = ec; v.e_mtval = em; v.e_target = etg;
      return v;
   endfunction

   // Reference model: walk the priority lists in order; first hit wins
   function automatic vec_t model(input vec_t vin);
      vec_t        v;
      int          irq_ord[3];
      int          scode[4];
      logic        sreq[4];
      logic [31:0] base;
      v = vin;
      irq_ord = '{11, 3, 7};
      scode   = '{0, 2, 3, 11};
      sreq    = '{v.fm, v.ill, v.ebrk, v.ecall};
      v.e_trap = 1'b0; v.e_ret = 1'b0; v.e_cause = '0; v.e_mtval = '0; v.e_target = '0;
      if (!v.valid) return v;
      if (v.mstatus[3] && !v.wen)
         for (int i = 0; i < 3; i++)
            if (!v.e_trap && v.mie[irq_ord[i]] && v.mip[irq_ord[i]]) begin
               v.e_trap  = 1'b1;
               v.e_cause = 32'h8000_0000 | 32'(irq_ord[i]);
            end
      for (int i = 0; i < 4; i++)
         if (!v.e_trap && sreq[i]) begin
            v.e_trap  = 1'b1;
            v.e_cause = 32'(scode[i]);
            if (scode[i] == 2)      v.e_mtval = v.inst;
            else if (scode[i] == 0) v.e_mtval = v.pc;
         end
      base = v.mtvec & 32'hFFFF_FFFC;
      if (v.e_trap) begin
         v.e_target = base;
`ifdef TRAP_VECTORED_EN
         if (v.e_cause[31] && v.mtvec[1:0] == 2'b01) v.e_target = base + 4 * v.e_cause[4:0];
`endif
      end else if (v.mret) begin
         v.e_ret    = 1'b1;
         v.e_target = v.mepc;
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus_if.ex_valid = v.valid;            bus_if.ex_pc = v.pc;
      bus_if.ex_inst = v.inst;              bus_if.ex_fetch_misaligned = v.fm;
      bus_if.ex_illegal = v.ill;            bus_if.ex_ebreak = v.ebrk;
      bus_if.ex_ecall = v.ecall;            bus_if.ex_mret = v.mret;
      bus_if.csr_wen = v.wen;               bus_if.csr_mstatus = v.mstatus;
      bus_if.csr_mie = v.mie;               bus_if.csr_mip = v.mip;
      bus_if.csr_mtvec = v.mtvec;           bus_if.csr_mepc = v.mepc;
   endtask

   task automatic clear_inputs();
      vec_t z;
      z = mk(1'b0, 0, 0, 6'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0);
      drive(z);
   endtask

   // One transaction: detect cycle N, pulse N+1, redirect N+2, back in IDLE at N+3
   task automatic apply(input string tag, input vec_t v);
      logic taken;
      taken = v.e_trap | v.e_ret;
      @(posedge clk); #1; drive(v);
      @(negedge clk);
      check({tag, " kill"}, 32'(bus_if.ex_kill), 32'(taken));
      check({tag, " stall_n@N"}, 32'(bus_if.stall_n), 32'd1);
      @(posedge clk); #1; clear_inputs();
      @(negedge clk);
      check({tag, " occurred"}, 32'(bus_if.exception_occurred), 32'(v.e_trap));
      check({tag, " returned"}, 32'(bus_if.exception_returned), 32'(v.e_ret));
      check({tag, " stall_n@N+1"}, 32'(bus_if.stall_n), 32'(!taken));
      if (v.e_trap) begin
         check({tag, " mcause"}, bus_if.new_mcause, v.e_cause);
         check({tag, " mepc"}, bus_if.new_mepc, v.pc);
         check({tag, " mtval"}, bus_if.new_mtval, v.e_mtval);
      end
      if (taken) begin
         @(posedge clk); #1;
         @(negedge clk);
         check({tag, " redirect"}, 32'(bus_if.pc_redirect), 32'd1);
         check({tag, " redirect_pc"}, bus_if.redirect_pc, v.e_target);
         check({tag, " stall_n@N+2"}, 32'(bus_if.stall_n), 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
         check({tag, " stall_n@N+3"}, 32'(bus_if.stall_n), 32'd1);
         check({tag, " redirect@N+3"}, 32'(bus_if.pc_redirect), 32'd0);
      end else begin
         check({tag, " no redirect"}, 32'(bus_if.pc_redirect), 32'd0);
      end
   endtask

   vec_t tbl[16];
   vec_t rv;

   initial begin
      tbl[0]  = mk(1, 32'h100, 32'h73, 6'b000100, 0, 0, 0, 32'h200, 0,
                   1, 0, 32'h0000_000B, 0, 32'h200);
      tbl[1]  = mk(1, 32'h300, 32'h13, 6'b000000, 32'h8, 32'h800, 32'h800, 32'h201, 0,
                   1, 0, 32'h8000_000B, 0, MeiVecTgt);
      tbl[2]  = mk(1, 32'h400, 32'h73, 6'b000100, 32'h8, 32'h88, 32'h88, 32'h200, 0,
                   1, 0, 32'h8000_0003, 0, 32'h200);
      tbl[3]  = mk(1, 32'h180, 32'h3020_0073, 6'b000010, 0, 0, 0, 32'h200, 32'h104,
                   0, 1, 0, 0, 32'h104);
      tbl[4]  = mk(1, 32'h500, 32'hDEAD_BEEF, 6'b010000, 0, 0, 0, 32'h1000, 0,
                   1, 0, 32'h2, 32'hDEAD_BEEF, 32'h1000);
      tbl[5]  = mk(1, 32'h602, 32'h1234, 6'b110000, 0, 0, 0, 32'h2000, 0,
                   1, 0, 32'h0, 32'h602, 32'h2000);
      tbl[6]  = mk(1, 32'h640, 32'h5555, 6'b001100, 0, 0, 0, 32'h300, 0,
                   1, 0, 32'h3, 0, 32'h300);
      tbl[7]  = mk(0, 32'h700, 32'h73, 6'b000100, 32'h8, 32'h800, 32'h800, 32'h200, 0,
                   0, 0, 0, 0, 0);
      tbl[8]  = mk(1, 32'h800, 32'h13, 6'b000000, 32'h0, 32'h800, 32'h800, 32'h200, 0,
                   0, 0, 0, 0, 0);
      tbl[9]  = mk(1, 32'h840, 32'h73, 6'b000110, 0, 0, 0, 32'h240, 32'h104,
                   1, 0, 32'hB, 0, 32'h240);
      tbl[10] = mk(1, 32'h900, 32'h0010_0073, 6'b001000, 32'h8, 32'h800, 32'h800, 32'h201, 0,
                   1, 0, 32'h8000_000B, 0, MeiVecTgt);
      tbl[11] = mk(1, 32'h940, 32'h0010_0073, 6'b001000, 0, 0, 0, 32'h201, 0,
                   1, 0, 32'h3, 0, 32'h200);
      tbl[12] = mk(1, 32'h980, 32'h13, 6'b000000, 32'h8, 32'h80, 32'h80, 32'h203, 0,
                   1, 0, 32'h8000_0007, 0, 32'h200);
      tbl[13] = mk(1, 32'h9C0, 32'h13, 6'b000000, 32'h8, 32'h2, 32'h2, 32'h200, 0,
                   0, 0, 0, 0, 0);
      tbl[14] = mk(1, 32'hA00, 32'h3020_0073, 6'b000011, 32'h8, 32'h800, 32'h800, 32'h200,
                   32'h104, 0, 1, 0, 0, 32'h104);
      tbl[15] = mk(1, 32'hA40, 32'h13, 6'b000000, 32'h8, 32'h8, 32'h8, 32'h101, 0,
                   1, 0, 32'h8000_0003, 0, MsiVecTgt);

      // Reset state
      rst_sync = 1'b1;
      clear_inputs();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst stall_n", 32'(bus_if.stall_n), 32'd1);
      check("rst kill", 32'(bus_if.ex_kill), 32'd0);
      check("rst occurred", 32'(bus_if.exception_occurred), 32'd0);
      check("rst returned", 32'(bus_if.exception_returned), 32'd0);
      check("rst redirect", 32'(bus_if.pc_redirect), 32'd0);
      check("rst mepc", bus_if.new_mepc, 32'd0);
      check("rst mcause", bus_if.new_mcause, 32'd0);
      check("rst mtval", bus_if.new_mtval, 32'd0);
      check("rst redirect_pc", bus_if.redirect_pc, 32'd0);
      @(posedge clk); #1 rst_sync = 1'b0;

      // Directed table
      for (int i = 0; i < 16; i++) apply($sformatf("vec%0d", i), tbl[i]);

      // Interrupt blocked by csr_wen, taken the following cycle
      @(posedge clk); #1;
      rv = mk(1, 32'hB00, 32'h13, 6'b000001, 32'h8, 32'h800, 32'h800, 32'h200, 0,
              0, 0, 0, 0, 0);
      drive(rv);
      @(negedge clk);
      check("wen kill blocked", 32'(bus_if.ex_kill), 32'd0);
      check("wen stall_n", 32'(bus_if.stall_n), 32'd1);
      @(posedge clk); #1 bus_if.csr_wen = 1'b0;
      @(negedge clk);
      check("wen kill next", 32'(bus_if.ex_kill), 32'd1);
      @(posedge clk); #1 clear_inputs();
      @(negedge clk);
      check("wen occurred", 32'(bus_if.exception_occurred), 32'd1);
      check("wen mcause", bus_if.new_mcause, 32'h8000_000B);
      check("wen mepc", bus_if.new_mepc, 32'hB00);
      @(posedge clk); #1;
      @(negedge clk);
      check("wen redirect_pc", bus_if.redirect_pc, 32'h200);
      @(posedge clk); #1;

      // Reset while in TRAP drops the pending redirect
      @(posedge clk); #1;
      rv = mk(1, 32'h1100, 32'h73, 6'b000100, 0, 0, 0, 32'h200, 0, 0, 0, 0, 0, 0);
      drive(rv);
      @(negedge clk);
      check("rstTrap kill", 32'(bus_if.ex_kill), 32'd1);
      @(posedge clk); #1 clear_inputs(); rst_sync = 1'b1;
      @(negedge clk);
      check("rstTrap stall in TRAP", 32'(bus_if.stall_n), 32'd0);
      @(posedge clk); #1 rst_sync = 1'b0;
      @(negedge clk);
      check("rstTrap stall_n", 32'(bus_if.stall_n), 32'd1);
      check("rstTrap redirect", 32'(bus_if.pc_redirect), 32'd0);
      check("rstTrap occurred", 32'(bus_if.exception_occurred), 32'd0);
      check("rstTrap mepc", bus_if.new_mepc, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstTrap redirect later", 32'(bus_if.pc_redirect), 32'd0);
      check("rstTrap stall_n later", 32'(bus_if.stall_n), 32'd1);

      // Random transactions against the reference model
      for (int i = 0; i < 300; i++) begin
         rv = mk($urandom_range(3) != 0, $urandom & 32'hFFFF_FFFC, $urandom,
                 6'(0), $urandom, $urandom, $urandom, $urandom, $urandom, 0, 0, 0, 0, 0);
         rv.fm    = ($urandom_range(7) == 0);
         rv.ill   = ($urandom_range(5) == 0);
         rv.ebrk  = ($urandom_range(5) == 0);
         rv.ecall = ($urandom_range(5) == 0);
         rv.mret  = ($urandom_range(3) == 0);
         rv.wen   = ($urandom_range(3) == 0);
         rv.mie   = rv.mie & ($urandom_range(1) != 0 ? 32'hFFFF_FFFF : 32'hFFFF_F777);
         rv.mip   = rv.mip & ($urandom_range(1) != 0 ? 32'hFFFF_FFFF : 32'hFFFF_F777);
         rv = model(rv);
         apply($sformatf("rnd%0d", i), rv);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
